// File: rtl/result_reader.sv
// result_reader: drains the first num_rows rows of result SRAMs a, b and c
// (in that order) and serializes every row lane by lane onto a valid/ready
// word stream for host dump and comparison.
module result_reader #(
    parameter int ARRAY_SIZE        = 16,
    parameter int OUTPUT_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH        = 6
) (
    input  logic                                      clk,
    input  logic                                      srstn,
    input  logic                                      start,
    input  logic [ADDR_WIDTH:0]                       num_rows,
    output logic [ADDR_WIDTH-1:0]                     sram_raddr_a,
    output logic [ADDR_WIDTH-1:0]                     sram_raddr_b,
    output logic [ADDR_WIDTH-1:0]                     sram_raddr_c,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_a,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_b,
    input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   sram_rdata_c,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0]              out_data,
    output logic [1:0]                                out_set,
    output logic [ADDR_WIDTH-1:0]                     out_row,
    output logic [$clog2(ARRAY_SIZE)-1:0]             out_lane,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      done
);

    localparam int LANE_W = $clog2(ARRAY_SIZE);
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int ROW_W  = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    logic [CNT_W-1:0]        num_rows_reg;
    logic [1:0]              set_reg;
    logic [ADDR_WIDTH-1:0]   row_reg;
    logic [LANE_W-1:0]       lane_reg;
    logic [ROW_W-1:0]        row_buf_reg;

    logic [CNT_W-1:0]        num_rows_clamped;
    logic [ROW_W-1:0]        rdata_sel;
    logic                    accept;
    logic                    last_lane;
    logic                    last_row;
    logic                    last_set;

    logic [OUTPUT_DATA_WIDTH-1:0] lane_word [ARRAY_SIZE];

    // Requests above the SRAM depth are limited to the full depth.
    assign num_rows_clamped = (num_rows > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_rows;

    assign accept    = (state_reg == S_SEND) && out_ready;
    assign last_lane = (lane_reg == LANE_W'(ARRAY_SIZE - 1));
    assign last_row  = ({1'b0, row_reg} == (num_rows_reg - CNT_W'(1)));
    assign last_set  = (set_reg == 2'd2);

    // Split the row buffer into lanes; lane 0 occupies the least significant bits.
    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            assign lane_word[gi] = row_buf_reg[gi*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
        end
    endgenerate

    // Pick the read data of the SRAM currently being drained.
    always_comb begin
        case (set_reg)
            2'd0:    rdata_sel = sram_rdata_a;
            2'd1:    rdata_sel = sram_rdata_b;
            default: rdata_sel = sram_rdata_c;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one fetch/capture pair per row, then one SEND per lane.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_rows == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_SEND;
            S_SEND: begin
                if (accept && last_lane) begin
                    state_next = (last_row && last_set) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Counters and row buffer; only a handshake in SEND advances the position.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            num_rows_reg <= '0;
            set_reg      <= '0;
            row_reg      <= '0;
            lane_reg     <= '0;
            row_buf_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        num_rows_reg <= num_rows_clamped;
                        set_reg      <= '0;
                        row_reg      <= '0;
                        lane_reg     <= '0;
                    end
                end
                S_CAPTURE: begin
                    row_buf_reg <= rdata_sel;
                    lane_reg    <= '0;
                end
                S_SEND: begin
                    if (accept) begin
                        if (!last_lane) begin
                            lane_reg <= lane_reg + LANE_W'(1);
                        end else if (!last_row) begin
                            row_reg <= row_reg + ADDR_WIDTH'(1);
                        end else if (!last_set) begin
                            set_reg <= set_reg + 2'd1;
                            row_reg <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and counters; idle addresses are parked at 0.
    always_comb begin
        sram_raddr_a = '0;
        sram_raddr_b = '0;
        sram_raddr_c = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_set      = '0;
        out_row      = '0;
        out_lane     = '0;
        out_last     = 1'b0;
        busy         = (state_reg != S_IDLE);
        done         = (state_reg == S_DONE);
        if (state_reg != S_IDLE) begin
            case (set_reg)
                2'd0:    sram_raddr_a = row_reg;
                2'd1:    sram_raddr_b = row_reg;
                default: sram_raddr_c = row_reg;
            endcase
        end
        if (state_reg == S_SEND) begin
            out_valid = 1'b1;
            out_data  = lane_word[lane_reg];
            out_set   = set_reg;
            out_row   = row_reg;
            out_lane  = lane_reg;
            out_last  = last_set && last_row && last_lane;
        end
    end

endmodule
